// File: rtl/alu_op_sequencer.sv
// Issue/sequencing controller for the 8-bit signed ALU: add/sub path, Booth multiplier, divider.
// Optional build macro DIV_ZERO_TRAP_EN traps DIV by zero without launching the divider.
module alu_op_sequencer #(
   parameter int ADDSUB_LAT = 1,
   parameter int TIMEOUT    = 32
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [7:0]  req_a,
   input  logic [7:0]  req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic        rsp_carry,
   output logic [3:0]  rsp_flags,
   output logic        rsp_err,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [1:0]  alu_op,
   output logic        alu_enable,
   input  logic [7:0]  alu_result,
   input  logic        alu_carry,
   input  logic [3:0]  alu_flags,
   output logic        mul_start,
   input  logic        mul_done,
   input  logic [15:0] mul_product,
   output logic        div_start,
   input  logic        div_done,
   input  logic [7:0]  div_quot,
   input  logic [7:0]  div_rem,
   output logic        busy,
   output logic [2:0]  dbg_state
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ADDSUB  = 3'd1;
   localparam logic [2:0] S_MUL_RUN = 3'd2;
   localparam logic [2:0] S_DIV_RUN = 3'd3;
   localparam logic [2:0] S_RESP    = 3'd4;

   localparam logic [1:0] OP_MULT = 2'b10;
   localparam logic [1:0] OP_DIV  = 2'b11;

   localparam logic [7:0] LP_AS_LAST  = 8'(ADDSUB_LAT - 1);
   localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

   logic [2:0]  r_state;
   logic [7:0]  r_cnt;
   logic [7:0]  r_alu_a;
   logic [7:0]  r_alu_b;
   logic [1:0]  r_alu_op;
   logic        r_mul_start;
   logic        r_div_start;
   logic [15:0] r_rsp_result;
   logic        r_rsp_carry;
   logic [3:0]  r_rsp_flags;
   logic        r_rsp_err;

   logic        w_accept;
   logic        w_trap;
   logic        w_in_engine;
   logic        w_eng_done;
   logic        w_eng_tmo;
   logic [15:0] w_eng_result;
   logic        w_as_last;

   // Both channels: a transfer happens on a rising edge where valid and ready are both high;
   // valid, once raised, holds its payload stable until that edge.
   assign w_accept = req_valid && (r_state == S_IDLE);

`ifdef DIV_ZERO_TRAP_EN
   assign w_trap = (req_op == OP_DIV) && (req_b == 8'd0);
`else
   assign w_trap = 1'b0;
`endif

   assign w_in_engine  = (r_state == S_MUL_RUN) || (r_state == S_DIV_RUN);
   assign w_eng_result = (r_state == S_MUL_RUN) ? mul_product : {div_rem, div_quot};
   // r_cnt is zero only in the start cycle, where a done from the previous op is ignored.
   assign w_eng_done   = w_in_engine && (r_cnt != 8'd0) &&
                         ((r_state == S_MUL_RUN) ? mul_done : div_done);
   assign w_eng_tmo    = w_in_engine && (r_cnt == LP_TMO_LAST);
   assign w_as_last    = (r_state == S_ADDSUB) && (r_cnt == LP_AS_LAST);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state      <= S_IDLE;
         r_cnt        <= 8'd0;
         r_alu_a      <= 8'd0;
         r_alu_b      <= 8'd0;
         r_alu_op     <= 2'd0;
         r_mul_start  <= 1'b0;
         r_div_start  <= 1'b0;
         r_rsp_result <= 16'd0;
         r_rsp_carry  <= 1'b0;
         r_rsp_flags  <= 4'd0;
         r_rsp_err    <= 1'b0;
      end else begin
         r_mul_start <= 1'b0;
         r_div_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_alu_a  <= req_a;
                  r_alu_b  <= req_b;
                  r_alu_op <= req_op;
                  r_cnt    <= 8'd0;
                  if (!req_op[1]) begin
                     r_state <= S_ADDSUB;
                  end else if (w_trap) begin
                     r_rsp_result <= 16'h0000;
                     r_rsp_carry  <= 1'b0;
                     r_rsp_flags  <= 4'b0001;
                     r_rsp_err    <= 1'b1;
                     r_state      <= S_RESP;
                  end else if (req_op == OP_MULT) begin
                     r_mul_start <= 1'b1;
                     r_state     <= S_MUL_RUN;
                  end else begin
                     r_div_start <= 1'b1;
                     r_state     <= S_DIV_RUN;
                  end
               end
            end
            S_ADDSUB: begin
               if (w_as_last) begin
                  r_rsp_result <= {{8{alu_result[7]}}, alu_result};
                  r_rsp_carry  <= alu_carry;
                  r_rsp_flags  <= alu_flags;
                  r_rsp_err    <= 1'b0;
                  r_state      <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_MUL_RUN, S_DIV_RUN: begin
               // Completion takes priority over a timeout landing in the same cycle.
               if (w_eng_done) begin
                  r_rsp_result <= w_eng_result;
                  r_rsp_carry  <= 1'b0;
                  r_rsp_flags  <= {2'b00, w_eng_result[15], (w_eng_result == 16'd0)};
                  r_rsp_err    <= 1'b0;
                  r_state      <= S_RESP;
               end else if (w_eng_tmo) begin
                  r_rsp_result <= 16'h0000;
                  r_rsp_carry  <= 1'b0;
                  r_rsp_flags  <= 4'b0001;
                  r_rsp_err    <= 1'b1;
                  r_state      <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = (r_state == S_IDLE);
   assign rsp_valid  = (r_state == S_RESP);
   assign busy       = (r_state != S_IDLE);
   assign alu_enable = (r_state == S_ADDSUB);
   assign dbg_state  = r_state;

   assign rsp_result = r_rsp_result;
   assign rsp_carry  = r_rsp_carry;
   assign rsp_flags  = r_rsp_flags;
   assign rsp_err    = r_rsp_err;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_op     = r_alu_op;
   assign mul_start  = r_mul_start;
   assign div_start  = r_div_start;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: vector table through a response scoreboard plus hand-written
// sequences for timeout, backpressure, reset mid-operation and the DIV_ZERO_TRAP_EN build.
module tb_alu_op_sequencer;

   localparam int LAT = 1;
   localparam int TMO = 32;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [7:0]  req_a, req_b;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_result;
   logic        rsp_carry;
   logic [3:0]  rsp_flags;
   logic        rsp_err;
   logic [7:0]  alu_a, alu_b;
   logic [1:0]  alu_op;
   logic        alu_enable;
   logic [7:0]  alu_result;
   logic        alu_carry;
   logic [3:0]  alu_flags;
   logic        mul_start, mul_done;
   logic [15:0] mul_product;
   logic        div_start, div_done;
   logic [7:0]  div_quot, div_rem;
   logic        busy;
   logic [2:0]  dbg_state;

   alu_op_sequencer #(.ADDSUB_LAT(LAT), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RESET(RESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_carry(rsp_carry), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_enable(alu_enable),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_flags(alu_flags),
      .mul_start(mul_start), .mul_done(mul_done), .mul_product(mul_product),
      .div_start(div_start), .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem),
      .busy(busy), .dbg_state(dbg_state)
   );

   always #5 CLK = ~CLK;

   // ---------------- datapath models ----------------
   logic [8:0]         alu_sum;
   logic signed [15:0] sa, sb;
   int                 eng_n = 2;
   logic               mul_en = 1'b1;
   logic               div_en = 1'b1;
   int                 mc = 0;
   int                 dc = 0;

   always_comb begin
      if (alu_op == 2'b01) alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
      else                 alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
   end
   assign alu_result = alu_sum[7:0];
   assign alu_carry  = alu_sum[8];
   assign alu_flags  = {1'b0, alu_sum[7], (alu_sum[7:0] == 8'd0), alu_sum[8]};

   assign sa          = {{8{alu_a[7]}}, alu_a};
   assign sb          = {{8{alu_b[7]}}, alu_b};
   assign mul_product = sa * sb;

   always_comb begin
      if (alu_b == 8'd0) begin
         div_quot = 8'hFF;
         div_rem  = alu_a;
      end else begin
         div_quot = $signed(alu_a) / $signed(alu_b);
         div_rem  = $signed(alu_a) % $signed(alu_b);
      end
   end

   // Engines raise done in the eng_n-th cycle, counting the start-pulse cycle as 1.
   always @(posedge CLK) begin
      if (mul_start) mc <= 1;
      else if (mc != 0) mc <= (mc == eng_n - 1) ? 0 : mc + 1;
      if (div_start) dc <= 1;
      else if (dc != 0) dc <= (dc == eng_n - 1) ? 0 : dc + 1;
   end
   assign mul_done = mul_en && (mc != 0) && (mc == eng_n - 1);
   assign div_done = div_en && (dc != 0) && (dc == eng_n - 1);

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [21:0] exp_q[$];
   int start_cnt, en_cnt, rdy_bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ctl"}, {req_ready, rsp_valid, busy, alu_enable, mul_start, div_start}, 6'b100000);
      check({tag, "_rsp"}, {rsp_result, rsp_carry, rsp_flags, rsp_err}, 32'd0);
      check({tag, "_alu_regs"}, {alu_a, alu_b, alu_op}, 32'd0);
      check({tag, "_state"}, dbg_state, 32'd0);
   endtask

   always @(negedge CLK) begin
      if (mul_start || div_start) start_cnt++;
      if (alu_enable) en_cnt++;
      if (busy && req_ready) rdy_bad++;
   end

   // Scoreboard: one expected response is consumed per response handshake.
   always @(negedge CLK) begin
      if (RESET && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp actual=%0h expected=none",
                     {rsp_result, rsp_carry, rsp_flags, rsp_err});
         end else begin
            check("rsp{res,c,flags,err}", {rsp_result, rsp_carry, rsp_flags, rsp_err},
                  exp_q.pop_front());
         end
      end
   end

   task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int n, input int exp_lat, input logic [21:0] exp_rsp,
                         input int exp_starts, input int exp_en);
      int lat;
      int guard;
      bit seen;
      eng_n = n;
      exp_q.push_back(exp_rsp);
      @(negedge CLK);
      check("req_ready_idle", req_ready, 1);
      start_cnt = 0;
      en_cnt    = 0;
      rdy_bad   = 0;
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      req_a     = 8'($urandom_range(0, 255));
      req_b     = 8'($urandom_range(0, 255));
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat < 200) begin
         @(negedge CLK);
         if (rsp_valid) seen = 1'b1;
         else lat++;
      end
      check("rsp_latency", lat, exp_lat);
      guard = 0;
      while (!(rsp_valid && rsp_ready) && guard < 100) begin
         @(negedge CLK);
         guard++;
      end
      @(posedge CLK);
      #1;
      check("idle_after_hs", {busy, req_ready}, 2'b01);
      check("start_pulses", start_cnt, exp_starts);
      check("enable_cycles", en_cnt, exp_en);
      check("ready_low_while_busy", rdy_bad, 0);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      int          n;
      logic [15:0] res;
      logic        c;
      logic [3:0]  fl;
      logic        e;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                               input int n, input logic [15:0] res, input logic c,
                               input logic [3:0] fl, input logic e);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.n = n; v.res = res; v.c = c; v.fl = fl; v.e = e;
      return v;
   endfunction

   initial begin : watchdog
      #400000;
      n_fail++;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [21:0] held;
      int          guard;
      int          rv_cnt;

      req_valid = 1'b0;
      req_op    = 2'b00;
      req_a     = 8'd0;
      req_b     = 8'd0;
      rsp_ready = 1'b1;

      // flags from the bench ALU model are {0, N, Z, C}
      vecs.push_back(mk(2'b00, 8'd100, 8'd27, 0, 16'h007F, 1'b0, 4'b0000, 1'b0));
      vecs.push_back(mk(2'b01, 8'hFB,  8'd3,  0, 16'hFFF8, 1'b1, 4'b0101, 1'b0));
      vecs.push_back(mk(2'b00, 8'hC8,  8'h64, 0, 16'h002C, 1'b1, 4'b0001, 1'b0));
      vecs.push_back(mk(2'b00, 8'hFF,  8'h01, 0, 16'h0000, 1'b1, 4'b0011, 1'b0));
      vecs.push_back(mk(2'b01, 8'd3,   8'd3,  0, 16'h0000, 1'b1, 4'b0011, 1'b0));
      vecs.push_back(mk(2'b01, 8'd0,   8'd1,  0, 16'hFFFF, 1'b0, 4'b0100, 1'b0));
      vecs.push_back(mk(2'b10, 8'hF9,  8'd9,  9, 16'hFFC1, 1'b0, 4'b0010, 1'b0));
      vecs.push_back(mk(2'b10, 8'h0C,  8'hF6, 2, 16'hFF88, 1'b0, 4'b0010, 1'b0));
      vecs.push_back(mk(2'b10, 8'h7F,  8'h7F, 5, 16'h3F01, 1'b0, 4'b0000, 1'b0));
      vecs.push_back(mk(2'b10, 8'h80,  8'h80, 3, 16'h4000, 1'b0, 4'b0000, 1'b0));
      vecs.push_back(mk(2'b10, 8'd0,   8'd5,  4, 16'h0000, 1'b0, 4'b0001, 1'b0));
      vecs.push_back(mk(2'b10, 8'd3,   8'hFE, TMO, 16'hFFFA, 1'b0, 4'b0010, 1'b0));
      vecs.push_back(mk(2'b11, 8'd100, 8'd7,  6, 16'h020E, 1'b0, 4'b0000, 1'b0));
      vecs.push_back(mk(2'b11, 8'h9C,  8'd7,  2, 16'hFEF2, 1'b0, 4'b0010, 1'b0));
      vecs.push_back(mk(2'b11, 8'd7,   8'd100, 3, 16'h0700, 1'b0, 4'b0000, 1'b0));
      vecs.push_back(mk(2'b11, 8'd0,   8'd5,  2, 16'h0000, 1'b0, 4'b0001, 1'b0));

      repeat (3) @(posedge CLK);
      #1;
      check_reset("reset");
      @(negedge CLK);
      RESET = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].n,
                vecs[i].op[1] ? vecs[i].n + 1 : LAT + 1,
                {vecs[i].res, vecs[i].c, vecs[i].fl, vecs[i].e},
                vecs[i].op[1] ? 1 : 0, vecs[i].op[1] ? 0 : LAT);
      end

      // divider never finishes: abort after TMO wait cycles
      div_en = 1'b0;
      run_op(2'b11, 8'd100, 8'd7, 2, TMO + 1, {16'h0000, 1'b0, 4'b0001, 1'b1}, 1, 0);
      div_en = 1'b1;

`ifdef DIV_ZERO_TRAP_EN
      run_op(2'b11, 8'd5, 8'd0, 2, 1, {16'h0000, 1'b0, 4'b0001, 1'b1}, 0, 0);
`else
      run_op(2'b11, 8'd5, 8'd0, 4, 5, {16'h05FF, 1'b0, 4'b0000, 1'b0}, 1, 0);
`endif

      // response backpressure: held response, second request refused
      exp_q.push_back({16'h001E, 1'b0, 4'b0000, 1'b0});
      @(negedge CLK);
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_op    = 2'b00;
      req_a     = 8'd10;
      req_b     = 8'd20;
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      guard = 0;
      while (!rsp_valid && guard < 50) begin
         @(negedge CLK);
         guard++;
      end
      check("bp_rsp_seen", rsp_valid, 1);
      held      = {rsp_result, rsp_carry, rsp_flags, rsp_err};
      req_valid = 1'b1;
      req_op    = 2'b01;
      req_a     = 8'($urandom_range(0, 255));
      req_b     = 8'($urandom_range(0, 255));
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         check("bp_hold", {rsp_valid, rsp_result, rsp_carry, rsp_flags, rsp_err}, {1'b1, held});
         check("bp_no_accept", req_ready, 0);
      end
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge CLK);
      #1;
      check("bp_ready_after_hs", {req_ready, busy, rsp_valid}, 3'b100);
      check("bp_regs_kept", {alu_op, alu_a, alu_b}, {2'b00, 8'd10, 8'd20});

      // reset asserted in the middle of a multiply
      eng_n = 20;
      @(negedge CLK);
      req_valid = 1'b1;
      req_op    = 2'b10;
      req_a     = 8'd5;
      req_b     = 8'd6;
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      repeat (4) @(posedge CLK);
      #2;
      check("mid_mul_state", dbg_state, 3'd2);
      RESET = 1'b0;
      #1;
      check_reset("async_reset");
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      rv_cnt = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge CLK);
         if (rsp_valid || busy) rv_cnt++;
      end
      check("no_rsp_after_reset", rv_cnt, 0);

      run_op(2'b01, 8'd50, 8'd8, 2, LAT + 1, {16'h002A, 1'b1, 4'b0001, 1'b0}, 0, LAT);

      repeat (2) @(negedge CLK);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Issue/sequencing controller in front of the 8-bit signed ALU datapath. Accepts one operation at a time over a valid/ready request channel. Launches it on the single-cycle add/sub path, the multi-cycle Booth multiplier or the multi-cycle non-restoring divider, waits for completion with a timeout, and returns a registered result over a valid/ready response channel.

Parameters:
ADDSUB_LAT, 1, cycles from alu_enable assertion to valid alu_result/alu_carry/alu_flags (1..3).
TIMEOUT, 32, max cycles to wait for mul_done/div_done before aborting (2..255).

Ports:
CLK  in  1  system clock, rising edge.
RESET  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  sequencer can accept a request.
req_op  in  2  00 ADD, 01 SUB, 10 MULT, 11 DIV.
req_a  in  8  signed operand A.
req_b  in  8  signed operand B.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_result  out  16  result word.
rsp_carry  out  1  carry out (add/sub only).
rsp_flags  out  4  status flags.
rsp_err  out  1  timeout or trapped operation.
alu_a, alu_b  out  8  latched operands to datapath.
alu_op  out  2  latched op code to datapath.
alu_enable  out  1  add/sub path enable.
alu_result  in  8  add/sub result.
alu_carry  in  1  add/sub carry.
alu_flags  in  4  add/sub flags.
mul_start  out  1  one-cycle multiplier start pulse.
mul_done  in  1  multiplier finished.
mul_product  in  16  signed product.
div_start  out  1  one-cycle divider start pulse.
div_done  in  1  divider finished.
div_quot, div_rem  in  8  quotient, remainder.
busy  out  1  state != IDLE.

Behaviour:
- Reset (RESET=0, async): state IDLE; req_ready=1; rsp_valid=0; rsp_result=0; rsp_carry=0; rsp_flags=0; rsp_err=0; alu_a/alu_b/alu_op=0; alu_enable=0; mul_start=div_start=0; busy=0; counters=0. Reset mid-operation abandons the op; no response is produced.
- States: IDLE, ADDSUB, MUL_RUN, DIV_RUN, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch op/a/b into alu_* regs and go to ADDSUB (op 0x) or MUL_RUN/DIV_RUN. req_ready=0 in all other states; no back-to-back issue (min. one IDLE cycle between ops).
- ADDSUB: alu_enable=1 for exactly ADDSUB_LAT cycles. In the last one, capture rsp_result={{8{alu_result[7]}},alu_result}, rsp_carry=alu_carry, rsp_flags=alu_flags, rsp_err=0. Go to RESP.
- MUL_RUN/DIV_RUN: start pulse high on the first cycle in the state only. Wait counter cleared on entry, +1 per cycle. done is ignored in the start cycle. On done: capture MULT rsp_result=mul_product, DIV rsp_result={div_rem,div_quot}; rsp_carry=0; rsp_flags={2'b00,rsp_result[15],rsp_result==0}; rsp_err=0. Go to RESP.
- Timeout: if counter reaches TIMEOUT with no done → rsp_result=0, rsp_flags=4'b0001, rsp_err=1, RESP. Done and timeout in the same cycle: done wins.
- RESP: rsp_valid=1; outputs stable until rsp_valid&rsp_ready, then IDLE next cycle. rsp_ready while rsp_valid=0 is ignored.
- Latency req accept → rsp_valid: ADDSUB_LAT+1 cycles (add/sub); N+1 for an engine with done N cycles after start.
- alu_* operand regs hold the last accepted op until the next accept.

Optional Feature:
Macro DIV_ZERO_TRAP_EN.
- Defined: DIV with req_b==0 never pulses div_start. Goes directly from IDLE to RESP next cycle with rsp_result=16'h0000, rsp_flags=4'b0001, rsp_err=1.
- Not defined: DIV by zero is launched normally; the result is whatever the divider returns, or timeout.

Test Plan:
- ADD a=8'd100,b=8'd27, ADDSUB_LAT=1, rsp_ready=1 → rsp_valid 2 cycles after accept, rsp_result=16'h007F, rsp_carry=0.
- SUB a=-5,b=3 → rsp_result=16'hFFF8 (sign-extended -8); req_ready=0 from accept until the cycle after the handshake.
- MULT a=-7,b=9, model done 9 cycles after one-cycle mul_start → rsp_result=16'hFFC1, rsp_flags[1]=1, rsp_err=0.
- DIV a=100,b=7, divider never asserts div_done, TIMEOUT=32 → rsp_valid after 32 wait cycles, rsp_err=1, rsp_result=0.
- Response backpressure: rsp_ready=0 for 5 cycles → rsp_* held constant, new req_valid not accepted; after handshake req_ready=1 next cycle.
- RESET pulled low during MUL_RUN → all outputs at reset values immediately, no rsp_valid after release. With DIV_ZERO_TRAP_EN: DIV b=0 → no div_start, rsp_err=1 one cycle after accept.
